apple_placer: RTL and testbench
===============================

# apple_placer

Places a new apple on the 16×16 playfield. On request it takes a random candidate position and rejects it if it overlaps any live snake segment or the barrier. It then walks forward to the next free cell and publishes the result. It sits between the random-number source and the Snake game-logic stage, and supplies the `apple` position that Snake and the VGA renderer consume.

## Interface
Parameters:
- `SEGS`, 9: maximum snake segments in the packed `snake` bus.
- `POS_W`, 8: position width; `{x[7:4], y[3:0]}`.
- `APPLE_RST`, 8'h88: apple position after reset.
- `MAX_TRIES`, 256: candidates examined before giving up.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  level-sampled placement request; accepted only in IDLE.
- `snake`  in  SEGS*POS_W  packed body; segment i at `[i*8+7 : i*8]`, segment 0 is the head.
- `snake_len`  in  4  number of live segments.
- `barrier`  in  POS_W  barrier cell.
- `random_num`  in  POS_W  free-running random value.
- `apple`  out  POS_W  current apple position (registered).
- `busy`  out  1  placement in progress.
- `done`  out  1  one-cycle pulse; `apple` was updated on the same edge.
- `fail`  out  1  one-cycle pulse; no free cell found, `apple` unchanged.

## Operation
- States: IDLE, CHECK.
- **IDLE**
  - `busy`=0.
  - On `req`=1: capture `snake`, `barrier` and effective length into shadow registers.
  - Effective length is `snake_len` clamped: 0→1, >9→9.
  - Set `cand`←`random_num`, `idx`←0, `tries`←0, `busy`←1, go to CHECK.
- **CHECK**, one comparison slot per cycle:
  - `hit` = (`cand` == shadow segment `idx`) OR (`idx`==0 AND `cand` == shadow barrier).
  - hit and `tries`==MAX_TRIES-1: pulse `fail`, go to IDLE.
  - hit otherwise: `cand`←`cand`+1 (mod 256), `idx`←0, `tries`←`tries`+1.
  - no hit, `idx`==len-1: `apple`←`cand`, pulse `done`, go to IDLE.
  - no hit otherwise: `idx`←`idx`+1.
- Live inputs are ignored while busy; all checks use the shadow copy.
- `req` held high re-triggers on the cycle after return to IDLE. Snake must drop `req` on `done`.
- Wrap-around: a candidate of 8'hFF plus 1 becomes 8'h00. Playfield coordinates wrap with it.
- Duplicate segment positions are legal and simply both compare.
- Reset at any time, mid-CHECK included, aborts the search:
  - `apple`=APPLE_RST, `busy`=0, `done`=0, `fail`=0, state IDLE.
  - `cand`, `idx` and `tries` are cleared.

## Timing
- `req` is sampled at edge T. `busy`=1 from T.
- No collision, length L: `done`=1 and new `apple` visible after edge T+L; `busy`=0 after T+L.
- A collision at slot k costs k+1 cycles before the next candidate starts at slot 0.
- Worst case: MAX_TRIES×L cycles, 2304 at L=9. At 25 MHz this is far below one 3.3 Hz game tick.
- `done` and `fail` are mutually exclusive. Each lasts exactly one cycle.

## Structure
- Shared package `snake_pkg`:
  - `SEGS`, `POS_W`, `GRID_BITS`=4.
  - Typedef `pos_t` (8-bit position) and the state enum.
- The segment select is an inline mux indexed by `idx`. No sub-module is needed.
- All registers reset asynchronously on `rst`=0.

## Test plan
- Reset, then release → `apple`=8'h88, `busy`=`done`=`fail`=0.
- `random_num`=8'h35, len 3, segments 8'h10/11/12, barrier 8'h77, `req` at edge T → `done` after T+3, `apple`=8'h35.
- `random_num`=8'h22, head 8'h22, seg1 8'h23, barrier 8'h24, len 2 → 8'h22, 8'h23 and 8'h24 are rejected in turn → `apple`=8'h25, `done` 6 cycles after T.
- `random_num`=8'hFF, head 8'hFF, len 1, barrier 8'h00 → wraps past 8'h00 → `apple`=8'h01.
- MAX_TRIES=4, `random_num`=8'h40, segments 8'h40..43 (len 4) → `fail` pulses once, `apple` is unchanged, `done` never asserts.
- Assert `rst`=0 during CHECK, then change `snake` while busy on the next run:
  - The reset aborts the search with `apple`=8'h88.
  - The later run's result follows the captured shadow, not the changed `snake`.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the Snake playfield blocks.
package snake_pkg;

   localparam int SEGS      = 9;
   localparam int POS_W     = 8;
   localparam int GRID_BITS = 4;

   // Playfield position {x[7:4], y[3:0]}
   typedef logic [POS_W-1:0] pos_t;

   typedef enum logic {
      IDLE,
      CHECK
   } state_t;

endpackage

// File: rtl/apple_placer.sv
// Apple placer: starts from a random candidate cell and walks forward until it
// finds a cell free of live snake segments and the barrier. Each cycle makes
// one comparison against the captured (shadow) snake.
module apple_placer
   import snake_pkg::*;
#(
   parameter int                 SEGS      = 9,
   parameter int                 POS_W     = 8,
   parameter logic [POS_W-1:0]   APPLE_RST = 8'h88,
   parameter int                 MAX_TRIES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   input  logic [SEGS*POS_W-1:0]   snake,
   input  logic [3:0]              snake_len,
   input  logic [POS_W-1:0]        barrier,
   input  logic [POS_W-1:0]        random_num,
   output logic [POS_W-1:0]        apple,
   output logic                    busy,
   output logic                    done,
   output logic                    fail
);

   localparam int         TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [3:0] SEGS_LEN = 4'(SEGS);

   state_t           state, state_n;
   logic [POS_W-1:0] cand, cand_n;
   logic [3:0]       idx, idx_n;
   logic [TW-1:0]    tries, tries_n;
   logic [POS_W-1:0] apple_n;
   logic             done_n, fail_n;
   logic             capture;

   logic [POS_W-1:0] seg_sh [SEGS];
   logic [POS_W-1:0] bar_sh;
   logic [3:0]       len_sh;
   logic [3:0]       len_eff;

   logic [POS_W-1:0] seg_cur;
   logic             hit;

   // Clamp requested length into 1..SEGS
   always_comb begin
      len_eff = snake_len;
      if (snake_len == 4'd0)
         len_eff = 4'd1;
      else if (snake_len > SEGS_LEN)
         len_eff = SEGS_LEN;
   end

   // Select the shadow segment for the current comparison slot
   always_comb begin
      seg_cur = '0;
      for (int unsigned i = 0; i < SEGS; i++) begin
         if (idx == 4'(i))
            seg_cur = seg_sh[i];
      end
   end

   // Barrier is compared only in slot 0 of each candidate
   assign hit = (cand == seg_cur) || ((idx == 4'd0) && (cand == bar_sh));

   // Next-state and datapath decisions
   always_comb begin
      state_n = state;
      cand_n  = cand;
      idx_n   = idx;
      tries_n = tries;
      apple_n = apple;
      done_n  = 1'b0;
      fail_n  = 1'b0;
      capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               capture = 1'b1;
               cand_n  = random_num;
               idx_n   = '0;
               tries_n = '0;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (hit) begin
               if (tries == TW'(MAX_TRIES - 1)) begin
                  fail_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  cand_n  = cand + 1'b1;
                  idx_n   = '0;
                  tries_n = tries + 1'b1;
               end
            end else if (idx == 4'(len_sh - 4'd1)) begin
               apple_n = cand;
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Search state and published outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cand  <= '0;
         idx   <= '0;
         tries <= '0;
         apple <= APPLE_RST;
         done  <= 1'b0;
         fail  <= 1'b0;
      end else begin
         state <= state_n;
         cand  <= cand_n;
         idx   <= idx_n;
         tries <= tries_n;
         apple <= apple_n;
         done  <= done_n;
         fail  <= fail_n;
      end
   end

   // Shadow copy of the snake taken when a request is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < SEGS; i++)
            seg_sh[i] <= '0;
         bar_sh <= '0;
         len_sh <= 4'd1;
      end else if (capture) begin
         for (int unsigned i = 0; i < SEGS; i++)
            seg_sh[i] <= snake[i*POS_W +: POS_W];
         bar_sh <= barrier;
         len_sh <= len_eff;
      end
   end

   assign busy = (state == CHECK);

endmodule

// File: tb/tb_apple_placer.sv
// Self-checking bench for apple_placer: a candidate-walk model predicts the
// result and the cycle count; a compare process checks outputs every cycle.
module tb_apple_placer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic [71:0] snake;
   logic [3:0]  snake_len;
   logic [7:0]  barrier, random_num;
   logic [7:0]  apple_a, apple_b;
   logic        busy_a, busy_b, done_a, done_b, fail_a, fail_b;

   int vectors     = 0;
   int miscompares = 0;

   bit         chk_en = 1'b0;
   int         sel    = 0;
   logic [7:0] exp_apple;
   logic       exp_busy, exp_done, exp_fail;
   logic [7:0] model_apple [2];
   logic [7:0] cur_seg [9];

   always #5 clk = ~clk;

   apple_placer dut_a (
      .clk(clk), .rst(rst), .req(req_a), .snake(snake), .snake_len(snake_len),
      .barrier(barrier), .random_num(random_num), .apple(apple_a),
      .busy(busy_a), .done(done_a), .fail(fail_a)
   );

   apple_placer #(.MAX_TRIES(4)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .snake(snake), .snake_len(snake_len),
      .barrier(barrier), .random_num(random_num), .apple(apple_b),
      .busy(busy_b), .done(done_b), .fail(fail_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of the selected instance against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",  sel ? busy_b  : busy_a,  exp_busy);
         check("done",  sel ? done_b  : done_a,  exp_done);
         check("fail",  sel ? fail_b  : fail_a,  exp_fail);
         check("apple", sel ? apple_b : apple_a, exp_apple);
      end
   end

   // Candidate walk: each candidate costs slots up to and including its first
   // hit, or the full length if it is free.
   function automatic void model(input logic [7:0] rnd, input logic [3:0] ln,
                                 input logic [7:0] bar, input int max_tries,
                                 output logic [7:0] res, output int cyc, output bit fl);
      int         l;
      logic [7:0] c;
      int         k;
      l   = (ln == 0) ? 1 : ((ln > 9) ? 9 : int'(ln));
      c   = rnd;
      cyc = 0;
      fl  = 1'b1;
      res = 8'h00;
      for (int t = 0; t < max_tries; t++) begin
         k = -1;
         for (int s = 0; s < l; s++) begin
            if (k < 0 && (cur_seg[s] == c || (s == 0 && c == bar)))
               k = s;
         end
         if (k >= 0) begin
            cyc += k + 1;
            c = c + 8'd1;
         end else begin
            cyc += l;
            res = c;
            fl  = 1'b0;
            break;
         end
      end
   endfunction

   task automatic fill_segs(input logic [7:0] v);
      for (int i = 0; i < 9; i++) cur_seg[i] = v;
   endtask

   task automatic pack_snake();
      for (int i = 0; i < 9; i++) snake[i*8 +: 8] = cur_seg[i];
   endtask

   task automatic run_case(input int s, input logic [7:0] rnd, input logic [3:0] ln,
                           input logic [7:0] bar, input bit scramble,
                           input logic [7:0] lit_apple, input int lit_cyc);
      logic [7:0] res;
      int         cyc;
      bit         fl;
      @(negedge clk);
      #1;
      pack_snake();
      snake_len  = ln;
      barrier    = bar;
      random_num = rnd;
      model(rnd, ln, bar, (s != 0) ? 4 : 256, res, cyc, fl);
      check("model_cycles", cyc, lit_cyc);
      sel       = s;
      exp_apple = model_apple[s];
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_fail  = 1'b0;
      if (s != 0) req_b = 1'b1; else req_a = 1'b1;
      @(posedge clk);
      #1;
      req_a = 1'b0;
      req_b = 1'b0;
      exp_busy   = 1'b1;
      random_num = ~rnd;
      if (scramble) begin
         fill_segs(rnd + 8'd1);
         pack_snake();
         barrier   = rnd + 8'd1;
         snake_len = 4'd9;
      end
      for (int n = 1; n < cyc; n++) @(posedge clk);
      @(posedge clk);
      #1;
      exp_busy = 1'b0;
      exp_done = !fl;
      exp_fail = fl;
      if (!fl) model_apple[s] = res;
      exp_apple = model_apple[s];
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      exp_fail = 1'b0;
      @(negedge clk);
      check("apple_literal", (s != 0) ? apple_b : apple_a, lit_apple);
   endtask

   initial begin
      rst        = 1'b0;
      req_a      = 1'b0;
      req_b      = 1'b0;
      snake      = '0;
      snake_len  = 4'd0;
      barrier    = 8'h00;
      random_num = 8'h00;
      fill_segs(8'hEE);
      model_apple[0] = 8'h88;
      model_apple[1] = 8'h88;
      exp_apple = 8'h88;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_fail  = 1'b0;
      #1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      check("reset_apple", apple_a, 8'h88);

      // Free first candidate, length 3
      fill_segs(8'hEE); cur_seg[0] = 8'h10; cur_seg[1] = 8'h11; cur_seg[2] = 8'h12;
      run_case(0, 8'h35, 4'd3, 8'h77, 1'b0, 8'h35, 3);

      // Head, segment 1 and barrier rejected in turn
      fill_segs(8'hEE); cur_seg[0] = 8'h22; cur_seg[1] = 8'h23;
      run_case(0, 8'h22, 4'd2, 8'h24, 1'b0, 8'h25, 6);

      // Wrap from FF through barrier at 00
      fill_segs(8'hEE); cur_seg[0] = 8'hFF;
      run_case(0, 8'hFF, 4'd1, 8'h00, 1'b0, 8'h01, 3);

      // Duplicate segment positions
      fill_segs(8'hEE); cur_seg[0] = 8'h51; cur_seg[1] = 8'h51; cur_seg[2] = 8'h70;
      run_case(0, 8'h51, 4'd3, 8'h00, 1'b0, 8'h52, 4);

      // Length 0 treated as 1
      fill_segs(8'h06); cur_seg[0] = 8'h05;
      run_case(0, 8'h05, 4'd0, 8'h77, 1'b0, 8'h06, 2);

      // Length 15 clamped to 9; collision in the last slot
      for (int i = 0; i < 9; i++) cur_seg[i] = 8'h80 + 8'(i);
      run_case(0, 8'h88, 4'd15, 8'h00, 1'b0, 8'h89, 18);

      // Give up after 4 candidates on the small instance
      fill_segs(8'hEE);
      cur_seg[0] = 8'h40; cur_seg[1] = 8'h41; cur_seg[2] = 8'h42; cur_seg[3] = 8'h43;
      run_case(1, 8'h40, 4'd4, 8'h00, 1'b0, 8'h88, 10);

      // Reset in the middle of a search
      @(negedge clk);
      #1;
      sel       = 0;
      exp_apple = model_apple[0];
      for (int i = 0; i < 9; i++) cur_seg[i] = 8'h60 + 8'(i);
      pack_snake();
      snake_len  = 4'd9;
      barrier    = 8'h00;
      random_num = 8'h50;
      req_a      = 1'b1;
      @(posedge clk);
      #1;
      req_a    = 1'b0;
      exp_busy = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_en = 1'b0;
      rst    = 1'b0;
      #1;
      check("abort_apple", apple_a, 8'h88);
      check("abort_busy",  busy_a,  1'b0);
      check("abort_done",  done_a,  1'b0);
      check("abort_fail",  fail_a,  1'b0);
      model_apple[0] = 8'h88;
      model_apple[1] = 8'h88;
      exp_apple = 8'h88;
      exp_busy  = 1'b0;
      @(negedge clk);
      #1;
      rst    = 1'b1;
      chk_en = 1'b1;

      // Live snake changed while busy: result follows the captured copy
      fill_segs(8'hEE); cur_seg[0] = 8'h12; cur_seg[1] = 8'h30;
      run_case(0, 8'h12, 4'd2, 8'h77, 1'b1, 8'h13, 3);

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
